// File: rtl/arb2_burst_xfer.sv
// arb2_burst_xfer: runs a BURST-beat transfer for the granted client
// of a 2-client arbiter onto a shared valid/ready bus.
//
// Ports:
//   clk, rst         rising-edge clock, async active-low reset
//   gnt1, gnt2       grants from the arbiter (sampled in IDLE only)
//   data1, data2     client beat data (live, combinational to bus)
//   bus_ready        sink accepts the current beat
//   bus_valid        beat valid on the shared bus
//   bus_data         current owner's data (0 outside XFER)
//   bus_owner        latched owner: 0 = client 1, 1 = client 2
//   beat             beat index within the burst (0 outside XFER)
//   busy             burst in progress (XFER or DONE)
//   done1, done2     one-cycle burst-complete pulse per client
//   err              one-cycle watchdog abort pulse
//
// Optional: define ARB2_XFER_TIMEOUT_EN to build a 4-bit stall
// watchdog that aborts a burst after TIMEOUT stalled cycles.
// Without it err is tied 0 and stalls wait forever.

module arb2_burst_xfer #(
   parameter int DW      = 8,
   parameter int BURST   = 4,
   parameter int CW      = 2,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          gnt1,
   input  logic          gnt2,
   input  logic [DW-1:0] data1,
   input  logic [DW-1:0] data2,
   input  logic          bus_ready,
   output logic          bus_valid,
   output logic [DW-1:0] bus_data,
   output logic          bus_owner,
   output logic [CW-1:0] beat,
   output logic          busy,
   output logic          done1,
   output logic          done2,
   output logic          err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST    = CW'(BURST - 1);
   localparam logic [3:0]    TO_LAST = 4'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic [CW-1:0] cnt_q, cnt_d;

`ifdef ARB2_XFER_TIMEOUT_EN
   logic [3:0] stall_q, stall_d;
   logic       to_q, to_d;
`else
   // the limit only matters when the watchdog is built
   logic [3:0] unused_to;
   assign unused_to = TO_LAST;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         cnt_q   <= '0;
`ifdef ARB2_XFER_TIMEOUT_EN
         stall_q <= '0;
         to_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
`ifdef ARB2_XFER_TIMEOUT_EN
         stall_q <= stall_d;
         to_q    <= to_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
`ifdef ARB2_XFER_TIMEOUT_EN
      stall_d = stall_q;
      to_d    = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
`ifdef ARB2_XFER_TIMEOUT_EN
            stall_d = '0;
`endif
            // client 1 wins if both grants are (illegally) high
            if (gnt1) begin
               owner_d = 1'b0;
               cnt_d   = '0;
               state_d = XFER;
            end else if (gnt2) begin
               owner_d = 1'b1;
               cnt_d   = '0;
               state_d = XFER;
            end
         end
         XFER: begin
            if (bus_ready) begin
`ifdef ARB2_XFER_TIMEOUT_EN
               stall_d = '0;
`endif
               if (cnt_q == LAST) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
`ifdef ARB2_XFER_TIMEOUT_EN
            // this stalled cycle is the TIMEOUT-th one
            else if (stall_q == TO_LAST) begin
               state_d = DONE;
               to_d    = 1'b1;
               stall_d = '0;
            end else begin
               stall_d = stall_q + 4'd1;
            end
`endif
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   logic xfer;
   logic fin;

   assign xfer      = (state_q == XFER);
   assign fin       = (state_q == DONE);
   assign bus_valid = xfer;
   assign bus_data  = xfer ? (owner_q ? data2 : data1) : '0;
   assign bus_owner = owner_q;
   assign beat      = xfer ? cnt_q : '0;
   assign busy      = (state_q != IDLE);
   assign done1     = fin & ~owner_q;
   assign done2     = fin & owner_q;

`ifdef ARB2_XFER_TIMEOUT_EN
   assign err = fin & to_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_arb2_burst_xfer.sv
// tb_arb2_burst_xfer: directed bench for arb2_burst_xfer with a
// scoreboard of expected bus beats.

module tb_arb2_burst_xfer;

   logic       clk;
   logic       rst;
   logic       gnt1, gnt2;
   logic [7:0] data1, data2;
   logic       bus_ready;
   logic       bus_valid;
   logic [7:0] bus_data;
   logic       bus_owner;
   logic [1:0] beat;
   logic       busy;
   logic       done1, done2;
   logic       err;

   int checks = 0;
   int errors = 0;
   int acc    = 0;

   // expected beat: {owner, beat, data}
   logic [10:0] sb[$];

   arb2_burst_xfer dut (
      .clk       (clk),
      .rst       (rst),
      .gnt1      (gnt1),
      .gnt2      (gnt2),
      .data1     (data1),
      .data2     (data2),
      .bus_ready (bus_ready),
      .bus_valid (bus_valid),
      .bus_data  (bus_data),
      .bus_owner (bus_owner),
      .beat      (beat),
      .busy      (busy),
      .done1     (done1),
      .done2     (done2),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] v(
      input logic       vl,
      input logic       ow,
      input logic [1:0] bt,
      input logic       bs,
      input logic       d1,
      input logic       d2,
      input logic       e
   );
      return {vl, ow, bt, bs, d1, d2, e};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic ow, input logic [1:0] bt,
                       input logic [7:0] d);
      sb.push_back({ow, bt, d});
   endtask

   // sample at the falling edge: scoreboard plus control outputs
   task automatic samp(input string tag, input logic [7:0] exp);
      logic [10:0] e;
      @(negedge clk);
      if (bus_valid && bus_ready) begin
         acc++;
         chk({tag, "_sb_pending"}, 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_sb_beat"}, {21'd0, bus_owner, beat, bus_data},
                {21'd0, e});
         end
      end
      if (!bus_valid) chk({tag, "_data0"}, 32'(bus_data), 0);
      chk(tag, 32'({bus_valid, bus_owner, beat, busy, done1, done2, err}),
          32'(exp));
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input logic [7:0] exp);
      samp(tag, exp);
      adv();
   endtask

   logic [7:0] IDLE0;
   logic       rdy_pat [6];
   logic [1:0] bt_pat  [6];

   initial begin
      IDLE0 = 8'h00;
      rst = 1'b0;
      gnt1 = 1'b0;
      gnt2 = 1'b0;
      data1 = 8'h00;
      data2 = 8'h00;
      bus_ready = 1'b0;

      // reset, then idle
      step("rst0", IDLE0);
      step("rst1", IDLE0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) step("idle", IDLE0);

      // client 1 burst, ready always high
      gnt1 = 1'b1;
      data1 = 8'hA5;
      bus_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(1'b0, 2'(i), 8'hA5);
      acc = 0;
      step("c1_idle", IDLE0);
      gnt1 = 1'b0;
      for (int i = 0; i < 4; i++)
         step("c1_beat", v(1, 0, 2'(i), 1, 0, 0, 0));
      step("c1_done", v(0, 0, 0, 1, 1, 0, 0));
      step("c1_after", IDLE0);
      chk("c1_beats", 32'(acc), 4);

      // client 2 burst with stalls, live data changes per cycle
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      bt_pat  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
      gnt2 = 1'b1;
      acc = 0;
      step("c2_idle", IDLE0);
      gnt2 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         bus_ready = rdy_pat[k];
         data2 = 8'h50 + 8'(k);
         if (rdy_pat[k]) push(1'b1, bt_pat[k], 8'h50 + 8'(k));
         step("c2_beat", v(1, 1, bt_pat[k], 1, 0, 0, 0));
      end
      bus_ready = 1'b1;
      step("c2_done", v(0, 1, 0, 1, 0, 1, 0));
      step("c2_after", v(0, 1, 0, 0, 0, 0, 0));
      chk("c2_beats", 32'(acc), 4);

      // simultaneous grants held high through the burst
      gnt1 = 1'b1;
      gnt2 = 1'b1;
      data1 = 8'h11;
      data2 = 8'hEE;
      for (int i = 0; i < 4; i++) push(1'b0, 2'(i), 8'h11);
      step("both_idle", v(0, 1, 0, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++)
         step("both_beat", v(1, 0, 2'(i), 1, 0, 0, 0));
      step("both_done", v(0, 0, 0, 1, 1, 0, 0));
      // back-to-back: gnt2 sampled the cycle after DONE
      gnt1 = 1'b0;
      gnt2 = 1'b1;
      data2 = 8'h22;
      for (int i = 0; i < 4; i++) push(1'b1, 2'(i), 8'h22);
      step("b2b_idle", IDLE0);
      gnt2 = 1'b0;
      for (int i = 0; i < 4; i++)
         step("b2b_beat", v(1, 1, 2'(i), 1, 0, 0, 0));
      step("b2b_done", v(0, 1, 0, 1, 0, 1, 0));
      step("b2b_after", v(0, 1, 0, 0, 0, 0, 0));

      // asynchronous reset during beat 2
      gnt1 = 1'b1;
      data1 = 8'h33;
      for (int i = 0; i < 3; i++) push(1'b0, 2'(i), 8'h33);
      step("rm_idle", v(0, 1, 0, 0, 0, 0, 0));
      gnt1 = 1'b0;
      step("rm_beat0", v(1, 0, 0, 1, 0, 0, 0));
      step("rm_beat1", v(1, 0, 1, 1, 0, 0, 0));
      samp("rm_beat2", v(1, 0, 2, 1, 0, 0, 0));
      #2 rst = 1'b0;
      #1 chk("rm_async",
             32'({bus_valid, bus_owner, beat, busy, done1, done2, err}), 0);
      chk("rm_async_data", 32'(bus_data), 0);
      adv();
      step("rm_held", IDLE0);
      rst = 1'b1;
      step("rm_idle2", IDLE0);
      step("rm_idle3", IDLE0);
      chk("sb_drained", 32'(sb.size()), 0);

      // stall with ready held low
      gnt1 = 1'b1;
      data1 = 8'h44;
      bus_ready = 1'b0;
      step("to_idle", IDLE0);
      gnt1 = 1'b0;
`ifdef ARB2_XFER_TIMEOUT_EN
      for (int k = 0; k < 15; k++)
         step("to_stall", v(1, 0, 0, 1, 0, 0, 0));
      step("to_done", v(0, 0, 0, 1, 1, 0, 1));
      step("to_after", IDLE0);
`else
      for (int k = 0; k < 20; k++)
         step("to_stall", v(1, 0, 0, 1, 0, 0, 0));
      acc = 0;
      bus_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(1'b0, 2'(i), 8'h44);
      for (int i = 0; i < 4; i++)
         step("to_drain", v(1, 0, 2'(i), 1, 0, 0, 0));
      step("to_done", v(0, 0, 0, 1, 1, 0, 0));
      step("to_after", IDLE0);
      chk("to_beats", 32'(acc), 4);
`endif
      chk("sb_final", 32'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
